multu_unit: RTL and testbench

MULTU_UNIT -- requirements
Module: multu_unit

---
 rtl/multu_unit.sv | 110 +++++++++++
 tb/tb_multu_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multu_unit.sv
// Unsigned WIDTH x WIDTH shift-add multiplier with architectural HI/LO registers.
// Define MULTU_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mcand, mcand_next;
    logic [2*WIDTH-1:0] prod, prod_next;
    logic [CW-1:0]      count, count_next;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] result;
    logic               finish;
`ifdef MULTU_EARLY_TERM_EN
    logic [2*WIDTH-1:0] pending_mask;
`endif

    always_comb begin
        state_next = state;
        mcand_next = mcand;
        prod_next  = prod;
        count_next = count;
        result     = prod;
        finish     = 1'b0;
        // Carry out of the upper half lands in bit WIDTH and is shifted back in.
        upper_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
`ifdef MULTU_EARLY_TERM_EN
        pending_mask = ~({(2*WIDTH){1'b1}} << count);
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_next = src_a;
                    prod_next  = {{WIDTH{1'b0}}, src_b};
                    count_next = CW'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                prod_next  = {upper_sum, prod[WIDTH-1:1]};
                count_next = count - CW'(1);
                result     = prod_next;
`ifdef MULTU_EARLY_TERM_EN
                // No further adds can occur, so the remaining shifts collapse into one.
                if ((prod & pending_mask) == '0) begin
                    result = prod >> count;
                    finish = 1'b1;
                end else if (count == CW'(1)) begin
                    finish = 1'b1;
                end
`else
                if (count == CW'(1)) begin
                    finish = 1'b1;
                end
`endif
                if (finish) begin
                    prod_next  = result;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            mcand <= mcand_next;
            prod  <= prod_next;
            count <= count_next;
            done  <= finish;
            if (finish) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end
        end
    end

    assign busy    = (state == RUN);
    assign stall   = busy & (start | rd_hi | rd_lo);
    assign rd_data = rd_hi ? hi : (rd_lo ? lo : '0);

endmodule

// File: tb/tb_multu_unit.sv
// Scoreboard bench for multu_unit: driver predicts product and completion cycle, monitor compares.
module tb_multu_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, rd_hi, rd_lo;
    logic [W-1:0] src_a, src_b, rd_data, hi, lo;
    logic         busy, stall, done;

    multu_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .rd_data(rd_data), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           last_start = 0;
    int           last_end = 0;
    int           tests = 0;
    int           fails = 0;
    int           done_count = 0;
    int           last_done_cyc = 0;
    logic [W-1:0] arch_hi = '0;
    logic [W-1:0] arch_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of RUN cycles an operation with multiplier b should take.
    function automatic int latency(input logic [W-1:0] b);
`ifdef MULTU_EARLY_TERM_EN
        int bits = 0;
        for (int i = 0; i < W; i++) if (b[i]) bits = i + 1;
        return (bits + 1 < W) ? bits + 1 : W;
`else
        return W;
`endif
    endfunction

    // Issue start across one edge; the model accepts it only if the unit is idle on that edge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        int          k;
        int          n;
        logic [63:0] p;
        @(negedge clk);
        src_a = a;
        src_b = b;
        start = 1'b1;
        k = cyc + 1;
        if (k > last_end) begin
            n = latency(b);
            p = 64'(a) * 64'(b);
            q.push_back('{p[63:32], p[31:0], k + n});
            last_start = k;
            last_end   = k + n;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: %0d results still pending after 200 cycles", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin : monitor
        bit           exp_done;
        bit           exp_busy;
        logic [W-1:0] exp_rd;
        #3;
        exp_done = (q.size() > 0) && (q[0].cyc == cyc);
        if (exp_done) begin
            arch_hi = q[0].hi;
            arch_lo = q[0].lo;
            void'(q.pop_front());
        end
        if (done) begin
            done_count++;
            last_done_cyc = cyc;
        end
        exp_busy = (cyc >= last_start) && (cyc < last_end);
        exp_rd   = rd_hi ? arch_hi : (rd_lo ? arch_lo : '0);
        check("mon_done", 64'(done), 64'(exp_done));
        check("mon_hi", 64'(hi), 64'(arch_hi));
        check("mon_lo", 64'(lo), 64'(arch_lo));
        check("mon_busy", 64'(busy), 64'(exp_busy));
        check("mon_stall", 64'(stall), 64'(exp_busy & (start | rd_hi | rd_lo)));
        check("mon_rd_data", 64'(rd_data), 64'(exp_rd));
    end

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dc0;
        int k;
        reset = 1'b1;
        start = 1'b0;
        src_a = '0;
        src_b = '0;
        rd_hi = 1'b0;
        rd_lo = 1'b1;
        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_rd_data", 64'(rd_data), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_lo = 1'b0;

        dc0 = done_count;
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("max_lo", 64'(lo), 64'h0000_0001);
        check("max_done_pulses", 64'(done_count - dc0), 64'd1);

        rd_lo = 1'b1;
        do_start(32'd3, 32'd5);
        wait_idle();
        #1;
        check("rdlo_stall", 64'(stall), 64'h0);
        check("rdlo_data", 64'(rd_data), 64'd15);
        rd_hi = 1'b1;
        #1;
        check("rdhi_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rd_hi = 1'b0;
        rd_lo = 1'b0;

        dc0 = done_count;
        do_start(32'd3, 32'd5);
        repeat (2) @(negedge clk);
        do_start(32'd7, 32'd9);
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_start_lo", 64'(lo), 64'd15);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_done_pulses", 64'(done_count - dc0), 64'd1);

        dc0 = done_count;
        do_start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        q.delete();
        last_start = 0;
        last_end = 0;
        arch_hi = '0;
        arch_lo = '0;
        #1;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_hi", 64'(hi), 64'h0);
        check("midrst_lo", 64'(lo), 64'h0);
        check("midrst_done", 64'(done), 64'h0);
        check("midrst_stall", 64'(stall), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_done_pulses", 64'(done_count - dc0), 64'd0);

        do_start(32'd7, 32'd3);
        k = last_start;
        wait_idle();
        check("early_lo", 64'(lo), 64'd21);
        check("early_hi", 64'(hi), 64'd0);
`ifdef MULTU_EARLY_TERM_EN
        check("early_latency", 64'(last_done_cyc - k), 64'd3);
`else
        check("early_latency", 64'(last_done_cyc - k), 64'd32);
`endif

        for (int i = 0; i < 400; i++) begin
            rd_hi = 1'($urandom_range(0, 1));
            rd_lo = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_start($urandom, $urandom >> $urandom_range(0, 31));
            end else begin
                @(negedge clk);
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
